binary_to_bcd_seq: RTL

Sequential shift-and-add-3 (double-dabble) converter from a parametrised binary word to packed BCD digits. It is the next generation of the bit-serial binary-to-decimal path, generalised in input width and digit count. It adds an optional two's-complement signed mode, a load/busy/done handshake and overflow detection. It sits between the binary datapath and the decimal display/output logic; one conversion is in flight at a time.

---
 rtl/binary_to_bcd_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter: W-bit binary (optionally two's complement)
// to N packed BCD digits, with load/busy/done handshake and overflow flag.
//
// state | meaning
// IDLE  | waiting for load, outputs hold last result
// SHIFT | add-3 and shift, one input bit per cycle, W cycles
// DONE  | result registered, done pulse; load here starts the next conversion
module binary_to_bcd_seq #(
  parameter int binaryNumberWidth = 32,
  parameter int numberOfDigits    = 10,
  parameter int busWidth          = 4,
  parameter bit signedMode        = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load,
  input  logic [binaryNumberWidth-1:0]        binaryNumber,
  output logic                                ready,
  output logic                                busy,
  output logic                                done,
  output logic [numberOfDigits*busWidth-1:0]  BinaryDecimal,
  output logic                                sign,
  output logic                                overflow
);

  localparam int W  = binaryNumberWidth;
  localparam int DW = numberOfDigits * busWidth;
  localparam int CW = $clog2(W + 1);

  if (busWidth != 4) begin : gBadBusWidth
    $error("binary_to_bcd_seq: busWidth must be 4");
  end
  if (W < 2) begin : gBadWidth
    $error("binary_to_bcd_seq: binaryNumberWidth must be >= 2");
  end
  if (numberOfDigits < 1) begin : gBadDigits
    $error("binary_to_bcd_seq: numberOfDigits must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, nextState;
  logic [W-1:0]    shiftReg;
  logic [DW-1:0]   bcdWork;
  logic            ovfSticky;
  logic            sgnCap;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            lastShift;
  logic [W-1:0]    mag;
  logic [DW-1:0]   bcdAdj;
  logic [DW-1:0]   bcdNext;
  logic [W-1:0]    shiftNext;
  logic            carryOut;

  // Most-negative input negates to itself, which is the correct unsigned magnitude.
  assign mag = (signedMode && binaryNumber[W-1]) ? (~binaryNumber) + W'(1) : binaryNumber;

  always_comb begin
    bcdAdj = bcdWork;
    for (int i = 0; i < numberOfDigits; i++) begin
      if (bcdWork[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcdWork[4*i +: 4] + 4'd3;
    end
    {carryOut, bcdNext, shiftNext} = {bcdAdj, shiftReg, 1'b0};
  end

  assign lastShift = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = load;
        if (load) nextState = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (lastShift) nextState = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        done      = 1'b1;
        accept    = load;
        nextState = load ? SHIFT : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shiftReg      <= '0;
      bcdWork       <= '0;
      ovfSticky     <= 1'b0;
      sgnCap        <= 1'b0;
      cnt           <= '0;
      BinaryDecimal <= '0;
      sign          <= 1'b0;
      overflow      <= 1'b0;
    end else if (accept) begin
      shiftReg  <= mag;
      sgnCap    <= signedMode && binaryNumber[W-1];
      bcdWork   <= '0;
      ovfSticky <= 1'b0;
      cnt       <= CW'(W);
    end else if (state == SHIFT) begin
      shiftReg  <= shiftNext;
      bcdWork   <= bcdNext;
      ovfSticky <= ovfSticky | carryOut;
      cnt       <= cnt - CW'(1);
      if (lastShift) begin
        BinaryDecimal <= bcdNext;
        overflow      <= ovfSticky | carryOut;
        sign          <= sgnCap;
      end
    end
  end

endmodule
